// File: rtl/pc_rstack.sv
// Fetch-stage program counter with a return-address stack (optional circular mode via PC_RSTACK_WRAP_EN).
// Latency: commands sampled on the rising edge; pc/count/flags reflect them right after that edge.
// Backpressure: none; a call on a full stack or a ret on an empty stack sets a sticky ovf/unf flag instead.
module pc_rstack #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inc,
  input  logic                         add,
  input  logic                         sub,
  input  logic                         jmp,
  input  logic                         call,
  input  logic                         ret,
  input  logic [WIDTH-1:0]             offset,
  input  logic [WIDTH-1:0]             target,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf,
  output logic                         unf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  // Stack storage is a circular buffer addressed by top (next free slot).
  // Because DEPTH is a power of two, the pointer wraps naturally, so in
  // circular mode a push on a full stack lands on the oldest entry.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_m1;
  logic [PW-1:0]    top_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;

  assign top_m1 = top - 1'b1;
  assign pc_inc = pc + 1'b1;

  // Command decode in priority order ret > call > jmp > sub > add > inc.
  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ret) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        pop    = 1'b1;
        pc_nxt = mem[top_m1];
      end
    end else if (call) begin
      if (full) begin
        ovf_set = 1'b1;
`ifdef PC_RSTACK_WRAP_EN
        push   = 1'b1;
        pc_nxt = target;
`else
        push   = 1'b0;
`endif
      end else begin
        push   = 1'b1;
        pc_nxt = target;
      end
    end else if (jmp) begin
      pc_nxt = target;
    end else if (sub) begin
      pc_nxt = pc - offset;
    end else if (add) begin
      pc_nxt = pc + offset;
    end else if (inc) begin
      pc_nxt = pc_inc;
    end
  end

  // Next stack pointer and occupancy; an overwriting push keeps count at DEPTH.
  always_comb begin
    top_nxt   = top;
    count_nxt = count;
    if (push) begin
      top_nxt = top + 1'b1;
      if (!full) begin
        count_nxt = count + 1'b1;
      end
    end else if (pop) begin
      top_nxt   = top_m1;
      count_nxt = count - 1'b1;
    end
  end

  // Return-address storage; not reset, and a push in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[top] <= pc_inc;
    end
  end

  // Architectural state; flags are registered from the next occupancy so they
  // always agree with count after each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_VEC;
      top   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      top   <= top_nxt;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      ovf   <= ovf | ovf_set;
      unf   <= unf | unf_set;
    end
  end

endmodule

// File: tb/tb_pc_rstack.sv
// Directed bench for pc_rstack with a queue-based reference model.
// The model is stepped once per applied command; a negedge process compares every cycle.
// Hand-computed literal checks pin the model at the key points of each scenario.
module tb_pc_rstack;
  localparam int W     = 16;
  localparam int D     = 8;
  localparam int CW    = $clog2(D+1);
  localparam logic [W-1:0] RV = 16'h0000;

  // Command bit positions: {reset, ret, call, jmp, sub, add, inc}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_INC  = 7'b0000001;
  localparam logic [6:0] C_ADD  = 7'b0000010;
  localparam logic [6:0] C_SUB  = 7'b0000100;
  localparam logic [6:0] C_JMP  = 7'b0001000;
  localparam logic [6:0] C_CALL = 7'b0010000;
  localparam logic [6:0] C_RET  = 7'b0100000;
  localparam logic [6:0] C_RST  = 7'b1000000;

  logic          clk = 1'b0;
  logic          reset, inc, add, sub, jmp, call, ret;
  logic [W-1:0]  offset, target;
  logic [W-1:0]  pc;
  logic [CW-1:0] count;
  logic          empty, full, ovf, unf;

  int vectors   = 0;
  int miscomps  = 0;
  bit chk_en    = 1'b0;

  // Reference model state
  logic [W-1:0]  m_pc;
  logic [W-1:0]  m_stk[$];
  logic          m_ovf, m_unf;

  pc_rstack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV)) dut (
    .clk(clk), .reset(reset), .inc(inc), .add(add), .sub(sub), .jmp(jmp),
    .call(call), .ret(ret), .offset(offset), .target(target),
    .pc(pc), .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] c, input logic [W-1:0] off, input logic [W-1:0] tgt);
    {reset, ret, call, jmp, sub, add, inc} = c;
    offset = off;
    target = tgt;
  endtask

  // Model: stack as a queue, newest at the back.
  task automatic model_step(input logic [6:0] c, input logic [W-1:0] off, input logic [W-1:0] tgt);
    if (c[6]) begin
      m_pc = RV; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (c[5]) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (c[4]) begin
      if (m_stk.size() == D) begin
        m_ovf = 1'b1;
`ifdef PC_RSTACK_WRAP_EN
        void'(m_stk.pop_front());
        m_stk.push_back(m_pc + W'(1));
        m_pc = tgt;
`endif
      end else begin
        m_stk.push_back(m_pc + W'(1));
        m_pc = tgt;
      end
    end else if (c[3]) m_pc = tgt;
    else if (c[2]) m_pc = m_pc - off;
    else if (c[1]) m_pc = m_pc + off;
    else if (c[0]) m_pc = m_pc + W'(1);
  endtask

  // One clock with command c, then idle inputs.
  task automatic apply(input logic [6:0] c, input logic [W-1:0] off, input logic [W-1:0] tgt);
    @(negedge clk);
    drive(c, off, tgt);
    @(posedge clk);
    model_step(c, off, tgt);
    #1;
    drive(C_NONE, '0, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscomps++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (pc !== m_pc || count !== CW'(m_stk.size()) ||
          empty !== (m_stk.size() == 0) || full !== (m_stk.size() == D) ||
          ovf !== m_ovf || unf !== m_unf) begin
        miscomps++;
        $display("FAIL model t=%0t: pc=%h cnt=%0d e=%b f=%b o=%b u=%b, expected pc=%h cnt=%0d o=%b u=%b",
                 $time, pc, count, empty, full, ovf, unf, m_pc, m_stk.size(), m_ovf, m_unf);
      end
    end
  end

  initial begin
    drive(C_NONE, '0, '0);
    m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state
    apply(C_RST, 0, 0);
    chk_en = 1'b1;
    chk("rst_pc", pc, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_flags", {full, ovf, unf}, 0);

    // Increment
    for (int k = 1; k <= 3; k++) begin
      apply(C_INC, 0, 0);
      chk("inc_pc", pc, k);
    end
    chk("inc_count", count, 0);
    chk("inc_empty", empty, 1);

    // Relative arithmetic and wrap
    apply(C_JMP, 0, 16'h0010);
    apply(C_ADD, 16'h0005, 0);
    chk("add", pc, 16'h0015);
    apply(C_SUB, 16'h0020, 0);
    chk("sub_wrap", pc, 16'hFFF5);
    apply(C_JMP, 0, 16'hFFFF);
    apply(C_INC, 0, 0);
    chk("inc_wrap", pc, 16'h0000);

    // Call / return
    apply(C_JMP, 0, 16'h0100);
    apply(C_CALL, 0, 16'h0200);
    chk("call1_pc", pc, 16'h0200);
    chk("call1_cnt", count, 1);
    apply(C_CALL, 0, 16'h0300);
    chk("call2_cnt", count, 2);
    apply(C_RET, 0, 0);
    chk("ret1_pc", pc, 16'h0201);
    apply(C_RET, 0, 0);
    chk("ret2_pc", pc, 16'h0101);
    chk("ret2_empty", empty, 1);

    // Underflow is sticky
    apply(C_JMP, 0, 16'h0042);
    apply(C_RET, 0, 0);
    chk("unf_pc", pc, 16'h0042);
    chk("unf_set", unf, 1);
    apply(C_INC, 0, 0);
    apply(C_INC, 0, 0);
    chk("unf_sticky", unf, 1);

    // Fill the stack, then one more call
    apply(C_RST, 0, 0);
    chk("rst_clears_unf", unf, 0);
    for (int k = 0; k < D; k++) apply(C_CALL, 0, W'(16'h1000 + k));
    chk("fill_cnt", count, D);
    chk("fill_full", full, 1);
    chk("fill_pc", pc, 16'h1007);
    apply(C_CALL, 0, 16'h0777);
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", count, D);
`ifdef PC_RSTACK_WRAP_EN
    chk("ovf_pc", pc, 16'h0777);
    for (int k = 0; k < D; k++) begin
      apply(C_RET, 0, 0);
      chk("wrap_ret", pc, 16'h1008 - k);
    end
`else
    chk("ovf_pc", pc, 16'h1007);
    for (int k = 0; k < D; k++) begin
      apply(C_RET, 0, 0);
      chk("rej_ret", pc, (k == D-1) ? 16'h0001 : 16'h1007 - k);
    end
`endif
    chk("drain_empty", empty, 1);
    chk("ovf_sticky", ovf, 1);

    // Priority
    apply(C_RST, 0, 0);
    apply(C_JMP, 0, 16'h0054);
    apply(C_CALL, 0, 16'h0099);
    apply(C_RET | C_CALL | C_INC, 0, 16'h0AAA);
    chk("prio_ret_pc", pc, 16'h0055);
    chk("prio_ret_cnt", count, 0);
    apply(C_JMP | C_SUB | C_ADD | C_INC, 16'h0003, 16'h0123);
    chk("prio_jmp", pc, 16'h0123);
    apply(C_SUB | C_ADD | C_INC, 16'h0003, 0);
    chk("prio_sub", pc, 16'h0120);
    apply(C_ADD | C_INC, 16'h0002, 0);
    chk("prio_add", pc, 16'h0122);

    // Reset beats a same-cycle call
    apply(C_CALL, 0, 16'h0010);
    apply(C_RST | C_CALL, 0, 16'h0333);
    chk("rst_call_pc", pc, RV);
    chk("rst_call_cnt", count, 0);

    // A few idle cycles checked by the model process
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end
endmodule
